// File: rtl/bk_save_sequencer_pkg.sv
// Shared types for the backup-RAM save/load sequencer.
// Holds the FSM state encoding, the operation kinds and the SD sector size.
package tgfx_bk_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACK  = 3'd2,
        NEXT = 3'd3,
        FIN  = 3'd4
    } bk_state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_SAVE = 2'd1,
        OP_AUTO = 2'd2
    } bk_op_t;

    localparam int SECT_BYTES = 512;

endpackage

// File: rtl/bk_save_sequencer_if.sv
// SD sector request bundle towards hps_io.
// master: drives sd_lba/sd_rd/sd_wr, samples sd_ack; slave: the opposite.
interface bk_save_sequencer_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );

endinterface

// File: rtl/bk_save_sequencer_dirty_map.sv
// Per-sector dirty bits: set/clear/clear-all, any-dirty flag, and the
// lowest dirty sector at or above from_idx. Set wins over a same-cycle clear.
module bk_dirty_map
    import tgfx_bk_pkg::*;
#(
    parameter int SECT_N = 16,
    parameter int SECT_W = $clog2(SECT_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [SECT_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [SECT_W-1:0] clr_idx,
    input  logic              clr_all,
    input  logic [SECT_W-1:0] from_idx,
    output logic              any,
    output logic              nxt_valid,
    output logic [SECT_W-1:0] nxt_idx
);

    logic [SECT_N-1:0] dirty;
    logic [SECT_N-1:0] dirty_d;

    always_comb begin
        dirty_d = dirty;
        if (clr_all) dirty_d = '0;
        if (clr_en)  dirty_d[clr_idx] = 1'b0;
        if (set_en)  dirty_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dirty <= '0;
        else     dirty <= dirty_d;
    end

    assign any = |dirty;

    // Descending scan so the lowest qualifying index is the last written.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_idx   = '0;
        for (int i = SECT_N - 1; i >= 0; i--) begin
            if (dirty[i] && (SECT_W'(i) >= from_idx)) begin
                nxt_valid = 1'b1;
                nxt_idx   = SECT_W'(i);
            end
        end
    end

endmodule

// File: rtl/bk_save_sequencer.sv
// Backup-RAM save/load sequencer: turns OSD load/save (and, with
// BK_AUTOSAVE_EN, OSD-open autosave) edges into runs of SD sector requests.
// Ports: clk_sys/reset, bk_ena, bk_load, bk_save, slot, osd_status,
// bram_wr/bram_waddr, sd (sd_lba/sd_rd/sd_wr/sd_ack), bk_busy/bk_loading/bk_done.
module bk_save_sequencer
    import tgfx_bk_pkg::*;
#(
    parameter int SECT_N = 16,
    parameter int ADDR_W = 12,
    parameter int SLOT_W = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_ena,
    input  logic              bk_load,
    input  logic              bk_save,
    input  logic [SLOT_W-1:0] slot,
    input  logic              osd_status,
    input  logic              bram_wr,
    input  logic [ADDR_W-1:0] bram_waddr,
    bk_save_sequencer_if.master sd,
    output logic              bk_busy,
    output logic              bk_loading,
    output logic              bk_done
);

    localparam int SECT_W = $clog2(SECT_N);
    localparam logic [SECT_W-1:0] LAST = SECT_W'(SECT_N - 1);

    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_REQ  = REQ;
    localparam logic [2:0] S_ACK  = ACK;
    localparam logic [2:0] S_NEXT = NEXT;
    localparam logic [2:0] S_FIN  = FIN;

    logic load_q, save_q, osd_q, ack_q;
    logic load_rise, save_rise, ack_rise, ack_fall;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
            save_q <= 1'b0;
            osd_q  <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            load_q <= bk_load;
            save_q <= bk_save;
            osd_q  <= osd_status;
            ack_q  <= sd.sd_ack;
        end
    end

    assign load_rise = bk_load & ~load_q;
    assign save_rise = bk_save & ~save_q;
    assign ack_rise  = sd.sd_ack & ~ack_q;
    assign ack_fall  = ~sd.sd_ack & ack_q;

    logic [2:0]        state;
    bk_op_t            op;
    logic [SLOT_W-1:0] slot_q;
    logic [SECT_W-1:0] sector;

    logic              auto_go;
    logic [SECT_W-1:0] auto_first;
    logic              auto_has;
    logic [SECT_W-1:0] auto_next;

`ifdef BK_AUTOSAVE_EN
    logic              d_any;
    logic              d_nv;
    logic [SECT_W-1:0] d_nidx;
    logic [SECT_W-1:0] from_idx;
    logic              unused_waddr;

    assign from_idx = (state == S_IDLE) ? '0 : sector + SECT_W'(1);

    bk_dirty_map #(
        .SECT_N (SECT_N),
        .SECT_W (SECT_W)
    ) u_dirty (
        .clk       (clk_sys),
        .rst       (reset),
        .set_en    (bram_wr),
        .set_idx   (bram_waddr[8 +: SECT_W]),
        .clr_en    (state == S_ACK && ack_fall && op != OP_LOAD),
        .clr_idx   (sector),
        .clr_all   (state == S_FIN && op == OP_LOAD),
        .from_idx  (from_idx),
        .any       (d_any),
        .nxt_valid (d_nv),
        .nxt_idx   (d_nidx)
    );

    assign auto_go      = osd_status & ~osd_q & d_any;
    assign auto_first   = d_nidx;
    assign auto_has     = d_nv;
    assign auto_next    = d_nidx;
    assign unused_waddr = ^bram_waddr[7:0];
`else
    logic unused_autosave;

    assign auto_go         = 1'b0;
    assign auto_first      = '0;
    assign auto_has        = 1'b0;
    assign auto_next       = '0;
    assign unused_autosave = ^{osd_q, osd_status, bram_wr, bram_waddr};
`endif

    // Start arbitration: load beats save beats autosave.
    logic              go;
    bk_op_t            go_op;
    logic [SECT_W-1:0] go_sect;

    always_comb begin
        go      = 1'b0;
        go_op   = OP_LOAD;
        go_sect = '0;
        if (bk_ena) begin
            if (load_rise) begin
                go = 1'b1;
            end else if (save_rise) begin
                go    = 1'b1;
                go_op = OP_SAVE;
            end else if (auto_go) begin
                go      = 1'b1;
                go_op   = OP_AUTO;
                go_sect = auto_first;
            end
        end
    end

    // Counter stops at LAST rather than wrapping.
    logic              has_next;
    logic [SECT_W-1:0] nxt;

    always_comb begin
        has_next = 1'b0;
        nxt      = sector + SECT_W'(1);
        if (sector != LAST) begin
            if (op == OP_AUTO) begin
                has_next = auto_has;
                nxt      = auto_next;
            end else begin
                has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            op         <= OP_LOAD;
            slot_q     <= '0;
            sector     <= '0;
            sd.sd_lba  <= '0;
            sd.sd_rd   <= 1'b0;
            sd.sd_wr   <= 1'b0;
            bk_busy    <= 1'b0;
            bk_loading <= 1'b0;
            bk_done    <= 1'b0;
        end else begin
            bk_done <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    op         <= go_op;
                    slot_q     <= slot;
                    sector     <= go_sect;
                    sd.sd_lba  <= 32'({slot, go_sect});
                    sd.sd_rd   <= (go_op == OP_LOAD);
                    sd.sd_wr   <= (go_op != OP_LOAD);
                    bk_busy    <= 1'b1;
                    bk_loading <= (go_op == OP_LOAD);
                    state      <= S_REQ;
                end
                S_REQ: if (ack_rise) begin
                    sd.sd_rd <= 1'b0;
                    sd.sd_wr <= 1'b0;
                    state    <= S_ACK;
                end
                S_ACK: if (ack_fall) state <= S_NEXT;
                S_NEXT: begin
                    if (has_next) begin
                        sector    <= nxt;
                        sd.sd_lba <= 32'({slot_q, nxt});
                        sd.sd_rd  <= (op == OP_LOAD);
                        sd.sd_wr  <= (op != OP_LOAD);
                        state     <= S_REQ;
                    end else begin
                        bk_done <= 1'b1;
                        state   <= S_FIN;
                    end
                end
                S_FIN: begin
                    bk_busy    <= 1'b0;
                    bk_loading <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bk_save_sequencer.sv
// Directed bench for bk_save_sequencer; models the HPS ack with 20-cycle pulses.
// Autosave scenarios run only when BK_AUTOSAVE_EN is defined.
module tb_bk_save_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        bk_ena  = 1'b0;
    logic        bk_load = 1'b0;
    logic        bk_save = 1'b0;
    logic [1:0]  slot    = '0;
    logic        osd_status = 1'b0;
    logic        bram_wr    = 1'b0;
    logic [11:0] bram_waddr = '0;
    logic        bk_busy, bk_loading, bk_done;

    bk_save_sequencer_if sd_if ();

    bk_save_sequencer dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bk_ena     (bk_ena),
        .bk_load    (bk_load),
        .bk_save    (bk_save),
        .slot       (slot),
        .osd_status (osd_status),
        .bram_wr    (bram_wr),
        .bram_waddr (bram_waddr),
        .sd         (sd_if),
        .bk_busy    (bk_busy),
        .bk_loading (bk_loading),
        .bk_done    (bk_done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic push_lba(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
    endtask

    task automatic wr_bram(input logic [11:0] a);
        bram_wr    = 1'b1;
        bram_waddr = a;
        tick(1);
        bram_wr    = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        logic act;
        act = 1'b0;
        repeat (n) begin
            @(negedge clk_sys);
            if (sd_if.sd_rd | sd_if.sd_wr | bk_busy | bk_done) act = 1'b1;
        end
        check(tag, {31'd0, act}, 32'd0);
    endtask

    // Serves requests until bk_done; stop_at>0 returns with ack held high
    // after that many requests. fall_wr writes sector 1 on the first ack fall.
    task automatic run_seq(input string tag, input logic is_rd, input int n_exp,
                           input int stop_at, input logic fall_wr);
        int nreq, ndone, idle;
        logic busy_ok, load_ok;
        logic [31:0] e;
        nreq = 0; ndone = 0; idle = 0;
        busy_ok = 1'b1; load_ok = 1'b1;
        while (ndone == 0 && idle < 200) begin
            @(negedge clk_sys);
            if (bk_done) ndone++;
            if (!bk_busy) busy_ok = 1'b0;
            if (bk_loading !== is_rd) load_ok = 1'b0;
            if (sd_if.sd_rd | sd_if.sd_wr) begin
                nreq++;
                idle = 0;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check({tag, "_lba"}, sd_if.sd_lba, e);
                check({tag, "_dir"}, {30'd0, sd_if.sd_rd, sd_if.sd_wr},
                      is_rd ? 32'd2 : 32'd1);
                sd_if.sd_ack = 1'b1;
                tick(20);
                check({tag, "_drop"}, {31'd0, sd_if.sd_rd | sd_if.sd_wr}, 32'd0);
                check({tag, "_hold"}, sd_if.sd_lba, e);
                if (nreq == stop_at) return;
                sd_if.sd_ack = 1'b0;
                if (fall_wr && nreq == 1) begin
                    bram_wr    = 1'b1;
                    bram_waddr = 12'h100;
                end
                tick(1);
                bram_wr = 1'b0;
            end else begin
                idle++;
            end
        end
        check({tag, "_done"}, 32'(ndone), 32'd1);
        check({tag, "_nreq"}, 32'(nreq), 32'(n_exp));
        check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_loading"}, {31'd0, load_ok}, 32'd1);
        check({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        sd_if.sd_ack = 1'b0;
        tick(3);
        check("rst_req", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
        check("rst_lba", sd_if.sd_lba, 32'd0);
        check("rst_flags", {29'd0, bk_busy, bk_loading, bk_done}, 32'd0);
        reset = 1'b0;
        tick(2);

        // 1: load slot 2
        bk_ena  = 1'b1;
        slot    = 2'd2;
        push_lba(32'h20, 16);
        bk_load = 1'b1;
        run_seq("t1", 1'b1, 16, 0, 1'b0);
        bk_load = 1'b0;
        quiet("t1_after", 10);

        // 2: gated save, then enabled save
        bk_ena  = 1'b0;
        slot    = 2'd0;
        bk_save = 1'b1;
        quiet("t2_gated", 30);
        bk_save = 1'b0;
        tick(2);
        bk_ena  = 1'b1;
        tick(1);
        push_lba(32'h00, 16);
        bk_save = 1'b1;
        run_seq("t2", 1'b0, 16, 0, 1'b0);
        bk_save = 1'b0;
        tick(3);

        // 3: simultaneous load and save rise
        slot    = 2'd1;
        push_lba(32'h10, 16);
        bk_load = 1'b1;
        bk_save = 1'b1;
        run_seq("t3", 1'b1, 16, 0, 1'b0);
        quiet("t3_nosave", 40);
        bk_load = 1'b0;
        bk_save = 1'b0;
        tick(3);

        // 6: reset in ACK of sector 5, then restart
        slot    = 2'd0;
        push_lba(32'h00, 6);
        bk_load = 1'b1;
        run_seq("t6a", 1'b1, 6, 6, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_rst_req", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
        check("t6_rst_flags", {30'd0, bk_busy, bk_loading}, 32'd0);
        exp_q.delete();
        @(negedge clk_sys);
        reset        = 1'b0;
        sd_if.sd_ack = 1'b0;
        bk_load      = 1'b0;
        quiet("t6_idle", 5);
        push_lba(32'h00, 16);
        bk_load = 1'b1;
        run_seq("t6b", 1'b1, 16, 0, 1'b0);
        bk_load = 1'b0;
        tick(3);

`ifdef BK_AUTOSAVE_EN
        // 4: autosave writes only dirty sectors 1 and 3
        wr_bram(12'h105);
        wr_bram(12'h3FF);
        tick(2);
        push_lba(32'h01, 1);
        push_lba(32'h03, 1);
        osd_status = 1'b1;
        run_seq("t4", 1'b0, 2, 0, 1'b0);
        osd_status = 1'b0;
        tick(2);
        osd_status = 1'b1;
        quiet("t4_clean", 40);
        osd_status = 1'b0;
        tick(2);

        // 5: write to sector 1 as its ack falls keeps it dirty
        wr_bram(12'h100);
        tick(2);
        push_lba(32'h01, 1);
        osd_status = 1'b1;
        run_seq("t5a", 1'b0, 1, 0, 1'b1);
        osd_status = 1'b0;
        tick(2);
        push_lba(32'h01, 1);
        osd_status = 1'b1;
        run_seq("t5b", 1'b0, 1, 0, 1'b0);
        osd_status = 1'b0;
        tick(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
